// File: rtl/param_mem_model_pkg.sv
// ---------------------------------------------------------------------------
// param_mem_model_pkg
// Shared defaults, the read-timer state type and a small helper for the
// parametrised memory model.
//   MEM_ADDR_WIDTH  : default byte-address bits decoded (256 KB)
//   MEM_DATA_WIDTH  : default data / instruction word width
//   MEM_RD_LATENCY  : default cycles from load accept to valid (1..8)
//   MEM_EXIT_ADDR   : default full 32-bit halt MMIO address
// ---------------------------------------------------------------------------
package param_mem_model_pkg;

  localparam int          MEM_ADDR_WIDTH = 18;
  localparam int          MEM_DATA_WIDTH = 32;
  localparam int          MEM_RD_LATENCY = 1;
  localparam logic [31:0] MEM_EXIT_ADDR  = 32'h0003_0004;

  // Read timer: IDLE (ready), WAIT (counting down), RESP (valid strobe)
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_RESP
  } rd_state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/param_mem_model_rd_timer.sv
// ---------------------------------------------------------------------------
// mem_rd_timer
// Load-latency sequencer for the data port: one outstanding read, countdown,
// one-cycle valid pulse and ready generation. All outputs are registered.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous, active-low reset
//   load_acc : a load was accepted at this edge (req && ready && !we)
//   ready    : port can accept a request this cycle
//   valid    : one-cycle load-data strobe
// ---------------------------------------------------------------------------
module mem_rd_timer
  import param_mem_model_pkg::*;
#(
  parameter int RD_LATENCY = MEM_RD_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic load_acc,
  output logic ready,
  output logic valid
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  rd_state_t        state;
  logic [CNT_W-1:0] cnt;

  // A new accept always wins; it can only arrive from IDLE or RESP because
  // ready is low throughout WAIT. With latency 1 the accept goes straight to
  // RESP so ready never drops. In WAIT the counter reaches 0 on the edge that
  // raises valid, so ready comes back in the same cycle as the data strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RD_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      valid <= 1'b0;
    end else if (load_acc) begin
      if (RD_LATENCY == 1) begin
        state <= RD_RESP;
        cnt   <= '0;
        ready <= 1'b1;
        valid <= 1'b1;
      end else begin
        state <= RD_WAIT;
        cnt   <= CNT_W'(RD_LATENCY - 1);
        ready <= 1'b0;
        valid <= 1'b0;
      end
    end else begin
      case (state)
        RD_WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            state <= RD_RESP;
            cnt   <= '0;
            ready <= 1'b1;
            valid <= 1'b1;
          end else begin
            cnt   <= cnt - CNT_W'(1);
            ready <= 1'b0;
            valid <= 1'b0;
          end
        end
        default: begin
          state <= RD_IDLE;
          ready <= 1'b1;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/param_mem_model.sv
// ---------------------------------------------------------------------------
// param_mem_model
// Parametrised clocked byte RAM with a combinational little-endian fetch port,
// a req/ready/valid data port with byte enables and programmable read
// latency, and a halt MMIO decode that latches an exit code.
// Optional: define MEM_MODEL_STATS_EN to add saturating access counters.
// Ports:
//   clk, rst             : clock / asynchronous active-low reset
//   inst_ce_i            : fetch enable
//   inst_addr_i          : fetch byte address
//   inst_o               : fetched word, zero when inst_ce_i low
//   mem_req_i, mem_we_i  : data request, 1 = store / 0 = load
//   mem_addr_i           : data byte address
//   mem_wdata_i          : store data
//   mem_sel_i            : byte-lane enables, bit k covers byte addr+k
//   mem_ready_o          : port can accept a request
//   mem_valid_o          : one-cycle load-data strobe
//   mem_rdata_o          : load data, held until the next load accept
//   halt_o, exit_code_o  : sticky halt flag and first halting store data
//   rd_cnt_o, wr_cnt_o, stall_cnt_o : (MEM_MODEL_STATS_EN only) counters
// ---------------------------------------------------------------------------
module param_mem_model
  import param_mem_model_pkg::*;
#(
  parameter int          ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int          DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int          RD_LATENCY = MEM_RD_LATENCY,
  parameter logic [31:0] EXIT_ADDR  = MEM_EXIT_ADDR,
  parameter int          SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ce_i,
  input  logic [31:0]           inst_addr_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [SEL_WIDTH-1:0]  mem_sel_i,
  output logic                  mem_ready_o,
  output logic                  mem_valid_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  halt_o,
  output logic [DATA_WIDTH-1:0] exit_code_o
`ifdef MEM_MODEL_STATS_EN
  ,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0]            ram [DEPTH];
  logic [ADDR_WIDTH-1:0] inst_base;
  logic [ADDR_WIDTH-1:0] data_base;
  logic [DATA_WIDTH-1:0] inst_word;
  logic [DATA_WIDTH-1:0] data_word;
  logic                  accept;
  logic                  load_acc;
  logic                  halt_acc;
  logic                  ram_wr;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the RAM; only the halt compare sees them
  assign inst_base      = inst_addr_i[ADDR_WIDTH-1:0];
  assign data_base      = mem_addr_i[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^inst_addr_i[31:ADDR_WIDTH];

  assign accept   = mem_req_i && mem_ready_o;
  assign load_acc = accept && !mem_we_i;
  assign halt_acc = accept && mem_we_i && (mem_addr_i == EXIT_ADDR);
  assign ram_wr   = accept && mem_we_i && (mem_addr_i != EXIT_ADDR);

  mem_rd_timer #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_timer (
    .clk      (clk),
    .rst      (rst),
    .load_acc (load_acc),
    .ready    (mem_ready_o),
    .valid    (mem_valid_o)
  );

  // Little-endian word assembly; addr+k wraps inside the address width
  always_comb begin
    inst_word = '0;
    data_word = '0;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      inst_word[8*k +: 8] = ram[inst_base + ADDR_WIDTH'(k)];
      data_word[8*k +: 8] = ram[data_base + ADDR_WIDTH'(k)];
    end
  end

  assign inst_o = inst_ce_i ? inst_word : '0;

  // RAM contents survive reset, so the array has no reset branch
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int k = 0; k < SEL_WIDTH; k++) begin
        if (mem_sel_i[k]) begin
          ram[data_base + ADDR_WIDTH'(k)] <= mem_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Load data is snapshotted at accept; only the first halt store sticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rdata_o <= '0;
      halt_o      <= 1'b0;
      exit_code_o <= '0;
    end else begin
      if (load_acc) begin
        mem_rdata_o <= data_word;
      end
      if (halt_acc && !halt_o) begin
        halt_o      <= 1'b1;
        exit_code_o <= mem_wdata_i;
      end
    end
  end

`ifdef MEM_MODEL_STATS_EN
  // Saturating access statistics; halt stores do not count as writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_o    <= '0;
      wr_cnt_o    <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (load_acc) begin
        rd_cnt_o <= sat_inc32(rd_cnt_o);
      end
      if (ram_wr) begin
        wr_cnt_o <= sat_inc32(wr_cnt_o);
      end
      if (mem_req_i && !mem_ready_o) begin
        stall_cnt_o <= sat_inc32(stall_cnt_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_mem_model.sv
// ---------------------------------------------------------------------------
// tb_param_mem_model
// Self-checking bench for param_mem_model. Three instances cover read
// latencies 1, 4 and 3; they share reset and the data/fetch buses but each
// has its own request line. Expected load data is queued when a load is
// driven and popped when the DUT raises valid.
// ---------------------------------------------------------------------------
module tb_param_mem_model;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  logic        inst_ce;
  logic [31:0] inst_addr;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic        req1, req4, req3;

  logic [31:0] inst1, rdata1, exit1;
  logic        ready1, valid1, halt1;
  logic [31:0] inst4, rdata4, exit4;
  logic        ready4, valid4, halt4;
  logic [31:0] inst3, rdata3, exit3;
  logic        ready3, valid3, halt3;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;

  param_mem_model #(.RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_o(inst1),
    .mem_req_i(req1), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel),
    .mem_ready_o(ready1), .mem_valid_o(valid1), .mem_rdata_o(rdata1),
    .halt_o(halt1), .exit_code_o(exit1)
  );

  param_mem_model #(.RD_LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_o(inst4),
    .mem_req_i(req4), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel),
    .mem_ready_o(ready4), .mem_valid_o(valid4), .mem_rdata_o(rdata4),
    .halt_o(halt4), .exit_code_o(exit4)
  );

  param_mem_model #(.RD_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_o(inst3),
    .mem_req_i(req3), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel),
    .mem_ready_o(ready3), .mem_valid_o(valid3), .mem_rdata_o(rdata3),
    .halt_o(halt3), .exit_code_o(exit3)
  );

  // Pop the next expected load word, or a poison value if none is queued
  task automatic pop_expected();
    if (exp_q.size() > 0) exp_word = exp_q.pop_front();
    else                  exp_word = 32'hBAD0_BAD0;
  endtask

  // One store on the selected instance (1, 4 or 3); returns one negedge later
  task automatic store_word(input int inst, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] sel);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = addr; mem_wdata = data; mem_sel = sel;
    req1 = (inst == 1); req4 = (inst == 4); req3 = (inst == 3);
    @(negedge clk);
    req1 = 1'b0; req4 = 1'b0; req3 = 1'b0; mem_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (ready1 !== 1'b0 || ready4 !== 1'b0 || ready3 !== 1'b0)
      $display("[TB] FAIL reset_ready: got %b%b%b want 000", ready1, ready4, ready3); else n_pass++;
    n_checks++; if (valid1 !== 1'b0 || rdata1 !== 32'h0)
      $display("[TB] FAIL reset_valid_rdata: got %b/%h want 0/0", valid1, rdata1); else n_pass++;
    n_checks++; if (halt1 !== 1'b0 || exit1 !== 32'h0)
      $display("[TB] FAIL reset_halt: got %b/%h want 0/0", halt1, exit1); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (ready1 !== 1'b0)
      $display("[TB] FAIL ready_before_edge: got %b want 0", ready1); else n_pass++;
    @(negedge clk);
    n_checks++; if (ready1 !== 1'b1 || ready4 !== 1'b1 || ready3 !== 1'b1)
      $display("[TB] FAIL ready_after_release: got %b%b%b want 111", ready1, ready4, ready3); else n_pass++;
  endtask

  task automatic test_store_load();
    store_word(1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    n_checks++; if (ready1 !== 1'b1 || valid1 !== 1'b0)
      $display("[TB] FAIL store_no_valid: got ready %b valid %b want 1/0", ready1, valid1); else n_pass++;
    @(negedge clk);
    req1 = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    req1 = 1'b0;
    pop_expected();
    n_checks++; if (valid1 !== 1'b1 || rdata1 !== exp_word)
      $display("[TB] FAIL lat1_load: got valid %b data %h want 1/%h", valid1, rdata1, exp_word); else n_pass++;
    n_checks++; if (ready1 !== 1'b1)
      $display("[TB] FAIL lat1_ready: got %b want 1", ready1); else n_pass++;
    @(negedge clk);
    n_checks++; if (valid1 !== 1'b0 || rdata1 !== 32'hDEAD_BEEF)
      $display("[TB] FAIL lat1_hold: got valid %b data %h want 0/deadbeef", valid1, rdata1); else n_pass++;
  endtask

  task automatic test_byte_lanes();
    store_word(1, 32'h200, 32'h1122_3344, 4'hF);
    inst_ce = 1'b1; inst_addr = 32'h200;
    @(negedge clk);
    req1 = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hAABB_CCDD; mem_sel = 4'b0101;
    #1;
    n_checks++; if (inst1 !== 32'h1122_3344)
      $display("[TB] FAIL lanes_before_edge: got %h want 11223344", inst1); else n_pass++;
    @(negedge clk);
    req1 = 1'b0; mem_we = 1'b0;
    n_checks++; if (inst1 !== 32'h11BB_33DD)
      $display("[TB] FAIL lanes_merge: got %h want 11bb33dd", inst1); else n_pass++;
    store_word(1, 32'h200, 32'h5555_5555, 4'b0000);
    n_checks++; if (inst1 !== 32'h11BB_33DD)
      $display("[TB] FAIL lanes_sel_zero: got %h want 11bb33dd", inst1); else n_pass++;
    inst_ce = 1'b0;
    #1;
    n_checks++; if (inst1 !== 32'h0)
      $display("[TB] FAIL fetch_disabled: got %h want 0", inst1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req1 = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    mem_addr = 32'h200;
    exp_q.push_back(32'h11BB_33DD);
    pop_expected();
    n_checks++; if (valid1 !== 1'b1 || rdata1 !== exp_word || ready1 !== 1'b1)
      $display("[TB] FAIL b2b_first: got v%b r%b %h want v1 r1 %h", valid1, ready1, rdata1, exp_word); else n_pass++;
    @(negedge clk);
    req1 = 1'b0;
    pop_expected();
    n_checks++; if (valid1 !== 1'b1 || rdata1 !== exp_word)
      $display("[TB] FAIL b2b_second: got v%b %h want v1 %h", valid1, rdata1, exp_word); else n_pass++;
    @(negedge clk);
    n_checks++; if (valid1 !== 1'b0)
      $display("[TB] FAIL b2b_valid_drop: got %b want 0", valid1); else n_pass++;
  endtask

  task automatic test_halt();
    store_word(1, 32'h4003_0004, 32'h5566_7788, 4'hF);
    store_word(1, 32'h0003_0004, 32'h0000_002A, 4'b0000);
    inst_ce = 1'b1; inst_addr = 32'h0003_0004;
    #1;
    n_checks++; if (halt1 !== 1'b1 || exit1 !== 32'd42)
      $display("[TB] FAIL halt_set: got %b/%0d want 1/42", halt1, exit1); else n_pass++;
    n_checks++; if (inst1 !== 32'h5566_7788)
      $display("[TB] FAIL halt_no_write: got %h want 55667788", inst1); else n_pass++;
    store_word(1, 32'h0003_0004, 32'd7, 4'hF);
    n_checks++; if (exit1 !== 32'd42 || halt1 !== 1'b1 || inst1 !== 32'h5566_7788)
      $display("[TB] FAIL halt_second: got %b/%0d/%h want 1/42/55667788", halt1, exit1, inst1); else n_pass++;
    n_checks++; if (ready1 !== 1'b1 || halt4 !== 1'b0)
      $display("[TB] FAIL halt_ready: got ready %b halt4 %b want 1/0", ready1, halt4); else n_pass++;
  endtask

  task automatic test_wrap_alias();
    store_word(1, 32'h0, 32'hCAFE_F00D, 4'hF);
    store_word(1, 32'h0003_FFFE, 32'h4433_2211, 4'hF);
    @(negedge clk);
    req1 = 1'b1; mem_we = 1'b0; mem_addr = 32'h0003_FFFE;
    exp_q.push_back(32'h4433_2211);
    @(negedge clk);
    mem_addr = 32'h4000_0100;
    exp_q.push_back(32'hDEAD_BEEF);
    pop_expected();
    n_checks++; if (valid1 !== 1'b1 || rdata1 !== exp_word)
      $display("[TB] FAIL wrap_load: got v%b %h want v1 %h", valid1, rdata1, exp_word); else n_pass++;
    @(negedge clk);
    req1 = 1'b0;
    pop_expected();
    n_checks++; if (valid1 !== 1'b1 || rdata1 !== exp_word)
      $display("[TB] FAIL alias_load: got v%b %h want v1 %h", valid1, rdata1, exp_word); else n_pass++;
    inst_ce = 1'b1; inst_addr = 32'h0;
    #1;
    n_checks++; if (inst1 !== 32'hCAFE_4433)
      $display("[TB] FAIL wrap_fetch: got %h want cafe4433", inst1); else n_pass++;
  endtask

  task automatic test_latency4();
    int cyc;
    store_word(4, 32'h100, 32'h1234_5678, 4'hF);
    store_word(4, 32'h104, 32'h9ABC_DEF0, 4'hF);
    @(negedge clk);
    req4 = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    exp_q.push_back(32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_addr = 32'h104;
      n_checks++; if (ready4 !== 1'b0 || valid4 !== 1'b0)
        $display("[TB] FAIL lat4_stall_%0d: got ready %b valid %b want 0/0", i, ready4, valid4); else n_pass++;
    end
    @(negedge clk);
    pop_expected();
    n_checks++; if (valid4 !== 1'b1 || ready4 !== 1'b1 || rdata4 !== exp_word)
      $display("[TB] FAIL lat4_resp: got v%b r%b %h want v1 r1 %h", valid4, ready4, rdata4, exp_word); else n_pass++;
    exp_q.push_back(32'h9ABC_DEF0);
    @(negedge clk);
    req4 = 1'b0;
    n_checks++; if (valid4 !== 1'b0 || ready4 !== 1'b0)
      $display("[TB] FAIL lat4_held_accept: got v%b r%b want v0 r0", valid4, ready4); else n_pass++;
    cyc = 1;
    while (valid4 !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    pop_expected();
    n_checks++; if (cyc != 4 || valid4 !== 1'b1 || rdata4 !== exp_word)
      $display("[TB] FAIL lat4_second: got cycle %0d data %h want cycle 4 data %h", cyc, rdata4, exp_word); else n_pass++;
    @(negedge clk);
    n_checks++; if (valid4 !== 1'b0 || ready4 !== 1'b1)
      $display("[TB] FAIL lat4_idle: got v%b r%b want v0 r1", valid4, ready4); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int seen;
    int cyc;
    store_word(3, 32'h100, 32'h0BAD_F00D, 4'hF);
    @(negedge clk);
    req3 = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    @(negedge clk);
    req3 = 1'b0;
    n_checks++; if (ready3 !== 1'b0)
      $display("[TB] FAIL lat3_busy: got %b want 0", ready3); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (ready3 !== 1'b0 || valid3 !== 1'b0 || rdata3 !== 32'h0 || halt1 !== 1'b0 || exit1 !== 32'h0)
      $display("[TB] FAIL mid_reset_state: got r%b v%b %h h%b %h want 0 0 0 0 0", ready3, valid3, rdata3, halt1, exit1); else n_pass++;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (valid3 === 1'b1) seen++;
    end
    rst = 1'b1;
    #1;
    n_checks++; if (ready3 !== 1'b0)
      $display("[TB] FAIL mid_reset_release: got %b want 0", ready3); else n_pass++;
    @(negedge clk);
    n_checks++; if (ready3 !== 1'b1)
      $display("[TB] FAIL mid_reset_ready: got %b want 1", ready3); else n_pass++;
    repeat (5) begin
      @(negedge clk);
      if (valid3 === 1'b1) seen++;
    end
    n_checks++; if (seen != 0)
      $display("[TB] FAIL dropped_read: got %0d valid pulses want 0", seen); else n_pass++;
    inst_ce = 1'b1; inst_addr = 32'h100;
    #1;
    n_checks++; if (inst3 !== 32'h0BAD_F00D || inst1 !== 32'hDEAD_BEEF)
      $display("[TB] FAIL ram_retained: got %h/%h want 0badf00d/deadbeef", inst3, inst1); else n_pass++;
    @(negedge clk);
    req3 = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    exp_q.push_back(32'h0BAD_F00D);
    @(negedge clk);
    req3 = 1'b0;
    cyc = 1;
    while (valid3 !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    pop_expected();
    n_checks++; if (cyc != 3 || rdata3 !== exp_word)
      $display("[TB] FAIL lat3_load: got cycle %0d data %h want cycle 3 data %h", cyc, rdata3, exp_word); else n_pass++;
  endtask

  // Tests run in order; later tests rely on RAM contents from earlier ones
  initial begin
    inst_ce = 1'b0; inst_addr = '0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_sel = '0;
    req1 = 1'b0; req4 = 1'b0; req3 = 1'b0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_back_to_back();
    test_halt();
    test_wrap_alias();
    test_latency4();
    test_reset_mid_read();
    n_checks++; if (exp_q.size() != 0)
      $display("[TB] FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
